// File: rtl/calc_input_seq.sv
// calc_input_seq -- operand/operation entry sequencer for a switch-and-button
// calculator front end.
//
// The user loads operand A, operand B and an operation code from the switches,
// advancing with btn_next; btn_clear aborts and zeroes everything. Both buttons
// are synchronized (2 flops), optionally debounced, and reduced to a one-cycle
// press pulse on each rising edge of the stable level.
//
// Build option:
//   CALC_SEQ_DEBOUNCE_EN  defined   -> per-button debouncer, level accepted after
//                                      DEBOUNCE_CYCLES consecutive differing cycles
//                         undefined -> stable level is the synchronized level and
//                                      DEBOUNCE_CYCLES is ignored
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sw         [N-1:0] operand switches
//   sel_sw     [3:0]   operation-select switches
//   btn_next   raw push button, advances the sequence
//   btn_clear  raw push button, aborts and clears
//   a, b       [N-1:0] registered operands
//   seleccion  [3:0]   registered operation code (0..9)
//   valid      a, b, seleccion form a complete operation
//   op_err     an illegal operation code was rejected
//   state      [1:0]   FSM state encoding for LED display
module calc_input_seq #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic [3:0]   sel_sw,
    input  logic         btn_next,
    input  logic         btn_clear,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [3:0]   seleccion,
    output logic         valid,
    output logic         op_err,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        SHOW    = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0] a_d, b_d;
    logic [3:0]   sel_d;
    logic         valid_d, op_err_d;

    // Button vectors: bit 0 = next, bit 1 = clear.
    logic [1:0] sync1, sync2;
    logic [1:0] stable, stable_prev;
    logic [1:0] press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            stable_prev <= '0;
        end else begin
            sync1       <= {btn_clear, btn_next};
            sync2       <= sync1;
            stable_prev <= stable;
        end
    end

`ifdef CALC_SEQ_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt [2];

    // The counter tracks how long the synchronized level has disagreed with the
    // accepted level; any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign stable = sync2;
`endif

    // Rising edge of the stable level only; releases and held levels give nothing.
    always_comb begin
        press = stable & ~stable_prev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD_A;
            a         <= '0;
            b         <= '0;
            seleccion <= '0;
            valid     <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a         <= a_d;
            b         <= b_d;
            seleccion <= sel_d;
            valid     <= valid_d;
            op_err    <= op_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a;
        b_d      = b;
        sel_d    = seleccion;
        valid_d  = valid;
        op_err_d = op_err;

        // Clear has priority; a simultaneous next press is dropped.
        if (press[1]) begin
            state_d  = LOAD_A;
            a_d      = '0;
            b_d      = '0;
            sel_d    = '0;
            valid_d  = 1'b0;
            op_err_d = 1'b0;
        end else if (press[0]) begin
            unique case (state_q)
                LOAD_A: begin
                    a_d     = sw;
                    state_d = LOAD_B;
                end
                LOAD_B: begin
                    b_d     = sw;
                    state_d = LOAD_OP;
                end
                LOAD_OP: begin
                    if (sel_sw <= 4'd9) begin
                        sel_d    = sel_sw;
                        op_err_d = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = SHOW;
                    end else begin
                        op_err_d = 1'b1;
                    end
                end
                SHOW: begin
                    valid_d = 1'b0;
                    state_d = LOAD_A;
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_calc_input_seq.sv
// tb_calc_input_seq -- self-checking bench for calc_input_seq (N=4,
// DEBOUNCE_CYCLES=4). Works with CALC_SEQ_DEBOUNCE_EN defined or undefined.
// A cycle-level reference model (button history windows plus the load rules)
// is compared against every DUT output on every clock, alongside directed
// scenario checks and a randomized stimulus phase.
module tb_calc_input_seq;

    localparam int N    = 4;
    localparam int DEB  = 4;
`ifdef CALC_SEQ_DEBOUNCE_EN
    localparam int LAT  = DEB + 3;
`else
    localparam int LAT  = 3;
`endif
    localparam int HOLD = DEB + 6;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] sw;
    logic [3:0]   sel_sw;
    logic         btn_next;
    logic         btn_clear;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   seleccion;
    logic         valid;
    logic         op_err;
    logic [1:0]   state;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    calc_input_seq #(
        .N               (N),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .sel_sw    (sel_sw),
        .btn_next  (btn_next),
        .btn_clear (btn_clear),
        .a         (a),
        .b         (b),
        .seleccion (seleccion),
        .valid     (valid),
        .op_err    (op_err),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[btn][j] = raw level sampled j clock edges ago (0 = this edge).
    bit           hist [2][16];
    bit           stab [2];
    bit           stab_prev [2];
    logic [N-1:0] ma, mb;
    logic [3:0]   msel;
    logic         mvalid, merr;
    int           mst;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 16; j++) hist[i][j] = 0;
            stab[i] = 0;
            stab_prev[i] = 0;
        end
        ma = '0; mb = '0; msel = '0; mvalid = 0; merr = 0; mst = 0;
    endtask

    task automatic model_step();
        bit p [2];
        bit raw [2];
        bit ns;
        raw[0] = btn_next;
        raw[1] = btn_clear;
        for (int i = 0; i < 2; i++) begin
            p[i] = stab[i] & ~stab_prev[i];
            for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = raw[i];
`ifdef CALC_SEQ_DEBOUNCE_EN
            // Accept the opposite level once the last DEB synchronized samples
            // (raw samples 2..DEB+1 edges ago) all show it.
            begin
                bit all_diff;
                all_diff = 1;
                for (int j = 2; j <= DEB + 1; j++)
                    if (hist[i][j] == stab[i]) all_diff = 0;
                ns = all_diff ? ~stab[i] : stab[i];
            end
`else
            ns = hist[i][1];
`endif
            stab_prev[i] = stab[i];
            stab[i] = ns;
        end
        if (p[1]) begin
            ma = '0; mb = '0; msel = '0; mvalid = 0; merr = 0; mst = 0;
        end else if (p[0]) begin
            if (mst == 0) begin
                ma = sw; mst = 1;
            end else if (mst == 1) begin
                mb = sw; mst = 2;
            end else if (mst == 2) begin
                if (sel_sw <= 9) begin
                    msel = sel_sw; merr = 0; mvalid = 1; mst = 3;
                end else begin
                    merr = 1;
                end
            end else begin
                mvalid = 0; mst = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        if (chk_en) begin
            check("cyc_a",     32'(a),         32'(ma));
            check("cyc_b",     32'(b),         32'(mb));
            check("cyc_sel",   32'(seleccion), 32'(msel));
            check("cyc_valid", 32'(valid),     32'(mvalid));
            check("cyc_err",   32'(op_err),    32'(merr));
            check("cyc_state", 32'(state),     mst);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit nx, input bit cl);
        @(negedge clk);
        btn_next  = nx;
        btn_clear = cl;
        wait_cyc(HOLD);
        btn_next  = 0;
        btn_clear = 0;
        wait_cyc(HOLD);
    endtask

    // Counts rising edges until state reaches target; 40 means it never did.
    task automatic measure_to(input logic [1:0] target, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (state == target) break;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(state),     0);
        check({tag, "_a"},     32'(a),         0);
        check({tag, "_b"},     32'(b),         0);
        check({tag, "_sel"},   32'(seleccion), 0);
        check({tag, "_valid"}, 32'(valid),     0);
        check({tag, "_err"},   32'(op_err),    0);
    endtask

    initial begin
        int n;
        rst_n = 0; btn_next = 0; btn_clear = 0; sw = '0; sel_sw = '0;
        wait_cyc(3);
        chk_en = 1;
        check_all_zero("reset");
        rst_n = 1;
        wait_cyc(2);

        // Full sequence and return to LOAD_A
        sw = 4'd3; press(1, 0);
        sw = 4'd5; press(1, 0);
        sel_sw = 4'd0; press(1, 0);
        check("seq_a",     32'(a),         3);
        check("seq_b",     32'(b),         5);
        check("seq_sel",   32'(seleccion), 0);
        check("seq_valid", 32'(valid),     1);
        check("seq_state", 32'(state),     3);
        press(1, 0);
        check("show_valid", 32'(valid), 0);
        check("show_state", 32'(state), 0);
        check("show_a",     32'(a),     3);
        check("show_b",     32'(b),     5);

        // Press latency
        sw = 4'd6;
`ifdef CALC_SEQ_DEBOUNCE_EN
        @(negedge clk); btn_next = 1;
        wait_cyc(3); btn_next = 0;
        wait_cyc(12);
        check("glitch_state", 32'(state), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn_next = (i % 2 == 0);
        end
`endif
        @(negedge clk); btn_next = 1;
        measure_to(2'b01, n);
        check("lat_cycles", 32'(n), LAT);
        check("lat_a",      32'(a), 6);
        @(negedge clk); wait_cyc(4); btn_next = 0; wait_cyc(HOLD);
        check("held_once_state", 32'(state), 1);

        // Clear from LOAD_B
        press(0, 1);
        check_all_zero("clear");

        // Illegal then legal operation code
        sw = 4'd1; press(1, 0);
        sw = 4'd2; press(1, 0);
        sel_sw = 4'd12; press(1, 0);
        check("ill_err",   32'(op_err),    1);
        check("ill_state", 32'(state),     2);
        check("ill_sel",   32'(seleccion), 0);
        sel_sw = 4'd7; press(1, 0);
        check("leg_err",   32'(op_err),    0);
        check("leg_sel",   32'(seleccion), 7);
        check("leg_valid", 32'(valid),     1);
        sel_sw = 4'd9; press(1, 0);

        // Next and clear together in SHOW
        sw = 4'd9; press(1, 0);
        sw = 4'd2; press(1, 0);
        sel_sw = 4'd1; press(1, 0);
        check("both_pre_state", 32'(state), 3);
        check("both_pre_a",     32'(a),     9);
        press(1, 1);
        check_all_zero("both");

        // Reset in LOAD_B with the button held through release
        sw = 4'd4; press(1, 0);
        check("rst_pre_state", 32'(state), 1);
        sw = 4'd11;
        @(negedge clk); btn_next = 1;
        wait_cyc(2);
        rst_n = 0;
        #1;
        check_all_zero("rst_mid");
        wait_cyc(2);
        rst_n = 1;
        measure_to(2'b01, n);
        check("rst_lat", 32'(n), LAT);
        check("rst_a",   32'(a), 11);
        @(negedge clk); wait_cyc(3); btn_next = 0; wait_cyc(HOLD);

        // Randomized phase, checked cycle by cycle against the model
        for (int it = 0; it < 250; it++) begin
            @(negedge clk);
            sw        = N'($urandom_range(0, (1 << N) - 1));
            sel_sw    = 4'($urandom_range(0, 15));
            btn_next  = 1'($urandom_range(0, 1));
            btn_clear = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 0;
                wait_cyc(2);
                rst_n = 1;
            end
            repeat ($urandom_range(0, 11)) @(negedge clk);
        end
        btn_next = 0; btn_clear = 0;
        wait_cyc(HOLD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
